// File: rtl/sbit_frame_emulator_pkg.sv
// sbit_frame_emulator_pkg: shared constants and types for the S-bit frame emulator.
// Optional feature macro: SBIT_EMU_PRBS_EN (enables the PRBS-7 payload source).
package sbit_frame_emulator_pkg;

    // Default number of bits per frame per lane
    localparam int SBIT_EMU_FRAME_SIZE = 8;

    // Payload source selection, latched when a burst starts
    localparam logic [1:0] SBIT_EMU_MODE_PASS = 2'd0;
    localparam logic [1:0] SBIT_EMU_MODE_WALK = 2'd1;
    localparam logic [1:0] SBIT_EMU_MODE_PRBS = 2'd2;
    localparam logic [1:0] SBIT_EMU_MODE_ZERO = 2'd3;

    // PRBS-7 seed, loaded at reset and at every burst start
    localparam logic [6:0] SBIT_EMU_PRBS_SEED = 7'h7F;

    // Burst sequencer states
    typedef enum logic [1:0] {
        SBIT_EMU_ST_IDLE  = 2'd0,
        SBIT_EMU_ST_RUN   = 2'd1,
        SBIT_EMU_ST_FLUSH = 2'd2
    } sbit_emu_state_e;

endpackage

// File: rtl/sbit_slip_tx.sv
// sbit_slip_tx: per-lane emulated bit-phase shifter.
// Output is the FRAME_SIZE-bit window of {cur,prev} selected by the slip value;
// slip 0 passes the current word unchanged.
module sbit_slip_tx
    import sbit_frame_emulator_pkg::*;
#(
    parameter int FRAME_SIZE = SBIT_EMU_FRAME_SIZE
) (
    input  logic [FRAME_SIZE-1:0]         i_cur,
    input  logic [FRAME_SIZE-1:0]         i_prev,
    input  logic [$clog2(FRAME_SIZE)-1:0] i_slip,
    output logic [FRAME_SIZE-1:0]         o_data
);

    localparam int SW = $clog2(FRAME_SIZE);
    localparam logic [SW:0] FS = (SW+1)'(FRAME_SIZE);

    logic [2*FRAME_SIZE-1:0] w_cat;
    logic [SW:0]             w_shamt;

    // Shift right by (FRAME_SIZE - slip) and keep the low word
    always_comb begin
        w_cat   = {i_cur, i_prev};
        w_shamt = FS - {1'b0, i_slip};
        o_data  = FRAME_SIZE'(w_cat >> w_shamt);
    end

endmodule

// File: rtl/sbit_frame_emulator.sv
// sbit_frame_emulator: VFAT3 trigger-path transmitter model producing per-lane
// S-bit frame words and the one-hot start-of-frame word.
// Optional feature macro: SBIT_EMU_PRBS_EN (PRBS-7 source for mode 2; when
// undefined, mode 2 emits all-zero payload and no LFSR exists).
module sbit_frame_emulator
    import sbit_frame_emulator_pkg::*;
#(
    parameter int MXSBITS    = 64,
    parameter int FRAME_SIZE = SBIT_EMU_FRAME_SIZE
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [MXSBITS-1:0]            sbits_i,
    input  logic [1:0]                    mode_i,
    input  logic [$clog2(FRAME_SIZE)-1:0] slip_i,
    input  logic                          slip_load_i,
    input  logic                          start_i,
    input  logic                          stop_i,
    input  logic [15:0]                   burst_len_i,
    input  logic                          sot_corrupt_i,
    output logic [MXSBITS-1:0]            frames_o,
    output logic [FRAME_SIZE-1:0]         sot_o,
    output logic                          busy_o,
    output logic [15:0]                   frame_cnt_o
);

    localparam int LANES = MXSBITS / FRAME_SIZE;
    localparam int SW    = $clog2(FRAME_SIZE);
    localparam int WW    = $clog2(MXSBITS);

    sbit_emu_state_e         r_state;
    logic [1:0]              r_mode;
    logic [15:0]             r_frame_cnt;
    logic [WW-1:0]           r_walk_idx;
    logic [SW-1:0]           r_slip;
    logic [SW-1:0]           r_slip_pend;
    logic                    r_slip_pend_v;
    logic [MXSBITS-1:0]      r_cur;
    logic [MXSBITS-1:0]      r_prev;
    logic [MXSBITS-1:0]      r_frames;
    logic [FRAME_SIZE-1:0]   r_sot;

    logic [MXSBITS-1:0]      w_src;
    logic [MXSBITS-1:0]      w_shifted;
    logic [15:0]             w_cnt_next;
    logic                    w_burst_done;
    logic [SW-1:0]           w_sot_idx;
    logic [FRAME_SIZE-1:0]   w_sot;

`ifdef SBIT_EMU_PRBS_EN
    logic [6:0]              r_prbs;
    logic [6:0]              w_prbs_next;
    logic [FRAME_SIZE-1:0]   w_prbs_word;

    // Step x^7+x^6+1 once per frame bit; inserted bits build the word LSB first
    always_comb begin
        w_prbs_next = r_prbs;
        w_prbs_word = '0;
        for (int i = 0; i < FRAME_SIZE; i++) begin
            w_prbs_word[i] = w_prbs_next[6] ^ w_prbs_next[5];
            w_prbs_next    = {w_prbs_next[5:0], w_prbs_word[i]};
        end
    end

    // LFSR state: reseeded on burst start, advanced once per RUN frame
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_prbs <= SBIT_EMU_PRBS_SEED;
        end else if (r_state == SBIT_EMU_ST_IDLE && start_i) begin
            r_prbs <= SBIT_EMU_PRBS_SEED;
        end else if (r_state == SBIT_EMU_ST_RUN) begin
            r_prbs <= w_prbs_next;
        end
    end
`endif

    // Saturating frame count and burst-length terminal detect (0 = continuous)
    always_comb begin
        w_cnt_next   = (r_frame_cnt == 16'hFFFF) ? r_frame_cnt : r_frame_cnt + 16'd1;
        w_burst_done = (burst_len_i != 16'd0) && (w_cnt_next == burst_len_i);
    end

    // Payload source: only RUN produces data, IDLE and FLUSH feed zeros
    always_comb begin
        w_src = '0;
        if (r_state == SBIT_EMU_ST_RUN) begin
            case (r_mode)
                SBIT_EMU_MODE_PASS: w_src = sbits_i;
                SBIT_EMU_MODE_WALK: w_src[r_walk_idx] = 1'b1;
`ifdef SBIT_EMU_PRBS_EN
                SBIT_EMU_MODE_PRBS: w_src = {LANES{w_prbs_word}};
`else
                SBIT_EMU_MODE_PRBS: w_src = '0;
`endif
                SBIT_EMU_MODE_ZERO: w_src = '0;
                default:            w_src = '0;
            endcase
        end
    end

    // Burst sequencer: IDLE -> RUN on start, RUN -> FLUSH on stop or count, FLUSH -> IDLE
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= SBIT_EMU_ST_IDLE;
            r_mode      <= SBIT_EMU_MODE_PASS;
            r_frame_cnt <= '0;
            r_walk_idx  <= '0;
        end else begin
            case (r_state)
                SBIT_EMU_ST_IDLE: begin
                    if (start_i) begin
                        r_state     <= SBIT_EMU_ST_RUN;
                        r_mode      <= mode_i;
                        r_frame_cnt <= '0;
                        r_walk_idx  <= '0;
                    end
                end
                SBIT_EMU_ST_RUN: begin
                    r_frame_cnt <= w_cnt_next;
                    r_walk_idx  <= (r_walk_idx == WW'(MXSBITS-1)) ? '0 : r_walk_idx + WW'(1);
                    if (stop_i || w_burst_done) begin
                        r_state <= SBIT_EMU_ST_FLUSH;
                    end
                end
                SBIT_EMU_ST_FLUSH: r_state <= SBIT_EMU_ST_IDLE;
                default:           r_state <= SBIT_EMU_ST_IDLE;
            endcase
        end
    end

    // Slip register: immediate in IDLE, otherwise parked and applied on the FLUSH -> IDLE edge
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_slip        <= '0;
            r_slip_pend   <= '0;
            r_slip_pend_v <= 1'b0;
        end else if (r_state == SBIT_EMU_ST_IDLE) begin
            if (slip_load_i) begin
                r_slip <= slip_i;
            end
        end else begin
            if (slip_load_i) begin
                r_slip_pend   <= slip_i;
                r_slip_pend_v <= 1'b1;
            end
            if (r_state == SBIT_EMU_ST_FLUSH) begin
                if (slip_load_i) begin
                    r_slip <= slip_i;
                end else if (r_slip_pend_v) begin
                    r_slip <= r_slip_pend;
                end
                r_slip_pend_v <= 1'b0;
            end
        end
    end

    // One phase shifter per lane, fed from the source and previous-source registers
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        sbit_slip_tx #(.FRAME_SIZE(FRAME_SIZE)) u_slip (
            .i_cur  (r_cur [g*FRAME_SIZE +: FRAME_SIZE]),
            .i_prev (r_prev[g*FRAME_SIZE +: FRAME_SIZE]),
            .i_slip (r_slip),
            .o_data (w_shifted[g*FRAME_SIZE +: FRAME_SIZE])
        );
    end

    // SoT marks bit (slip-1) mod FRAME_SIZE
    always_comb begin
        w_sot_idx        = r_slip - SW'(1);
        w_sot            = '0;
        w_sot[w_sot_idx] = 1'b1;
    end

    // Source register, previous-source register, then output registers for data and SoT
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cur    <= '0;
            r_prev   <= '0;
            r_frames <= '0;
            r_sot    <= FRAME_SIZE'(2);
        end else begin
            r_cur    <= w_src;
            r_prev   <= r_cur;
            r_frames <= w_shifted;
            r_sot    <= sot_corrupt_i ? '0 : w_sot;
        end
    end

    assign frames_o    = r_frames;
    assign sot_o       = r_sot;
    assign busy_o      = (r_state != SBIT_EMU_ST_IDLE);
    assign frame_cnt_o = r_frame_cnt;

endmodule

// File: tb/tb_sbit_frame_emulator.sv
// tb_sbit_frame_emulator: self-checking bench for sbit_frame_emulator.
// Honours SBIT_EMU_PRBS_EN for the expected PRBS payload.
module tb_sbit_frame_emulator;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [63:0] sbits_i;
    logic [1:0]  mode_i;
    logic [2:0]  slip_i;
    logic        slip_load_i;
    logic        start_i;
    logic        stop_i;
    logic [15:0] burst_len_i;
    logic        sot_corrupt_i;
    logic [63:0] frames_o;
    logic [7:0]  sot_o;
    logic        busy_o;
    logic [15:0] frame_cnt_o;

`ifdef SBIT_EMU_PRBS_EN
    localparam logic [63:0] PRBS_W1 = {8{8'h40}};
    localparam logic [63:0] PRBS_W2 = {8{8'h30}};
`else
    localparam logic [63:0] PRBS_W1 = 64'd0;
    localparam logic [63:0] PRBS_W2 = 64'd0;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Scoreboard: frames due two edges after the cycle they were driven, SoT one edge after
    logic [63:0] exp_q[$];
    int          due_q[$];
    string       tag_q[$];
    logic [7:0]  sot_exp_q[$];
    int          sot_due_q[$];

    sbit_frame_emulator u_dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .sbits_i       (sbits_i),
        .mode_i        (mode_i),
        .slip_i        (slip_i),
        .slip_load_i   (slip_load_i),
        .start_i       (start_i),
        .stop_i        (stop_i),
        .burst_len_i   (burst_len_i),
        .sot_corrupt_i (sot_corrupt_i),
        .frames_o      (frames_o),
        .sot_o         (sot_o),
        .busy_o        (busy_o),
        .frame_cnt_o   (frame_cnt_o)
    );

    // Clock and edge counter
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One driven cycle: clear pulses, drive payload, queue the expected frame word
    task automatic tick(input logic [63:0] sb, input logic [63:0] exp, input string tag);
        @(negedge clock);
        start_i       = 1'b0;
        stop_i        = 1'b0;
        slip_load_i   = 1'b0;
        sot_corrupt_i = 1'b0;
        sbits_i       = sb;
        exp_q.push_back(exp);
        due_q.push_back(cyc + 2);
        tag_q.push_back(tag);
    endtask

    task automatic push_sot(input logic [7:0] e);
        sot_exp_q.push_back(e);
        sot_due_q.push_back(cyc + 1);
    endtask

    // Scoreboard compare, away from the active edge
    always @(negedge clock) begin
        while (due_q.size() > 0 && due_q[0] <= cyc) begin
            check({tag_q[0], "_frames"}, frames_o, exp_q[0]);
            void'(exp_q.pop_front());
            void'(due_q.pop_front());
            void'(tag_q.pop_front());
        end
        while (sot_due_q.size() > 0 && sot_due_q[0] <= cyc) begin
            check("sot_q", {56'd0, sot_o}, {56'd0, sot_exp_q[0]});
            void'(sot_exp_q.pop_front());
            void'(sot_due_q.pop_front());
        end
    end

    initial begin
        logic [63:0] rv;
        reset_n = 1'b0; sbits_i = '0; mode_i = '0; slip_i = '0; slip_load_i = 1'b0;
        start_i = 1'b0; stop_i = 1'b0; burst_len_i = '0; sot_corrupt_i = 1'b0;

        // Reset values
        repeat (2) @(negedge clock);
        check("rst_frames", frames_o, 64'd0);
        check("rst_sot", {56'd0, sot_o}, 64'h02);
        check("rst_busy", {63'd0, busy_o}, 64'd0);
        check("rst_cnt", {48'd0, frame_cnt_o}, 64'd0);
        reset_n = 1'b1;
        @(negedge clock);
        check("idle_sot", {56'd0, sot_o}, 64'h80);

        // Pass-through, slip 0, stop mid-run, stray start in RUN and stop in IDLE
        tick(64'd0, 64'd0, "pass"); start_i = 1'b1; mode_i = 2'd0; burst_len_i = 16'd0; push_sot(8'h80);
        tick(64'h0123456789ABCDEF, 64'h0123456789ABCDEF, "pass");
        check("pass_busy_up", {63'd0, busy_o}, 64'd1); push_sot(8'h80);
        tick(64'hFEDCBA9876543210, 64'hFEDCBA9876543210, "pass"); start_i = 1'b1; mode_i = 2'd1; push_sot(8'h80);
        for (int i = 0; i < 5; i++) begin
            rv = {$urandom, $urandom};
            tick(rv, rv, "pass");
            push_sot(8'h80);
        end
        tick(64'hA5A5_5A5A_0F0F_F0F0, 64'hA5A5_5A5A_0F0F_F0F0, "pass"); stop_i = 1'b1;
        tick(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, "pass_flush");
        check("stop_busy_flush", {63'd0, busy_o}, 64'd1);
        tick(64'd0, 64'd0, "pass");
        check("stop_busy_down", {63'd0, busy_o}, 64'd0);
        check("stop_cnt", {48'd0, frame_cnt_o}, 64'd8);
        tick(64'd0, 64'd0, "pass"); stop_i = 1'b1;
        tick(64'd0, 64'd0, "pass");
        check("idle_stop_ign", {63'd0, busy_o}, 64'd0);
        check("stop_cnt_hold", {48'd0, frame_cnt_o}, 64'd8);

        // Slip 3 in IDLE, then a pending load of 5 during RUN
        tick(64'd0, 64'd0, "slip"); slip_load_i = 1'b1; slip_i = 3'd3;
        tick(64'd0, 64'd0, "slip"); start_i = 1'b1; mode_i = 2'd0; burst_len_i = 16'd0;
        check("slip_sot_old", {56'd0, sot_o}, 64'h80);
        tick(64'h00000000000000FF, 64'h00000000000000F8, "slip");
        check("slip_sot3", {56'd0, sot_o}, 64'h04);
        tick(64'd0, 64'h0000000000000007, "slip");
        tick(64'd0, 64'd0, "slip"); slip_load_i = 1'b1; slip_i = 3'd5;
        tick(64'd0, 64'd0, "slip"); stop_i = 1'b1;
        tick(64'd0, 64'd0, "slip");
        check("slip_pend_run", {56'd0, sot_o}, 64'h04);
        tick(64'd0, 64'd0, "slip");
        check("slip_pend_idle0", {56'd0, sot_o}, 64'h04);
        tick(64'd0, 64'd0, "slip");
        check("slip_pend_apply", {56'd0, sot_o}, 64'h10);
        slip_load_i = 1'b1; slip_i = 3'd0;
        tick(64'd0, 64'd0, "slip");
        check("slip_sot5", {56'd0, sot_o}, 64'h10);
        tick(64'd0, 64'd0, "slip");
        check("slip_sot0", {56'd0, sot_o}, 64'h80);

        // Walking one, 70-frame burst
        tick(64'd0, 64'd0, "walk"); start_i = 1'b1; mode_i = 2'd1; burst_len_i = 16'd70;
        for (int k = 0; k < 70; k++) begin
            tick(64'd0, 64'd1 << (k % 64), "walk");
            if (k == 0) check("walk_busy_up", {63'd0, busy_o}, 64'd1);
        end
        tick(64'd0, 64'd0, "walk");
        check("walk_busy_flush", {63'd0, busy_o}, 64'd1);
        tick(64'd0, 64'd0, "walk");
        check("walk_busy_down", {63'd0, busy_o}, 64'd0);
        check("walk_cnt", {48'd0, frame_cnt_o}, 64'd70);
        tick(64'd0, 64'd0, "walk");
        tick(64'd0, 64'd0, "walk");
        check("walk_cnt_hold", {48'd0, frame_cnt_o}, 64'd70);

        // PRBS bursts of 1 and 2 frames, each reseeded
        tick(64'd0, 64'd0, "prbs"); start_i = 1'b1; mode_i = 2'd2; burst_len_i = 16'd1;
        tick(64'd0, PRBS_W1, "prbs");
        tick(64'd0, 64'd0, "prbs");
        tick(64'd0, 64'd0, "prbs");
        check("prbs_cnt1", {48'd0, frame_cnt_o}, 64'd1);
        check("prbs_busy", {63'd0, busy_o}, 64'd0);
        tick(64'd0, 64'd0, "prbs"); start_i = 1'b1; mode_i = 2'd2; burst_len_i = 16'd2;
        tick(64'd0, PRBS_W1, "prbs");
        tick(64'd0, PRBS_W2, "prbs");
        tick(64'd0, 64'd0, "prbs");
        tick(64'd0, 64'd0, "prbs");
        check("prbs_cnt2", {48'd0, frame_cnt_o}, 64'd2);

        // SoT corruption: single pulse and a two-cycle pulse during RUN
        tick(64'd0, 64'd0, "corrupt"); start_i = 1'b1; mode_i = 2'd0; burst_len_i = 16'd0; push_sot(8'h80);
        for (int i = 0; i < 10; i++) begin
            rv = {$urandom, $urandom};
            tick(rv, rv, "corrupt");
            sot_corrupt_i = (i == 3 || i == 6 || i == 7);
            push_sot(sot_corrupt_i ? 8'h00 : 8'h80);
        end
        tick(64'd0, 64'd0, "corrupt"); stop_i = 1'b1; push_sot(8'h80);
        tick(64'd0, 64'd0, "corrupt"); push_sot(8'h80);
        tick(64'd0, 64'd0, "corrupt");
        check("corrupt_cnt", {48'd0, frame_cnt_o}, 64'd11);

        // Asynchronous reset in the middle of a continuous walking burst
        tick(64'd0, 64'd0, "rst"); start_i = 1'b1; mode_i = 2'd1; burst_len_i = 16'd0;
        for (int k = 0; k < 6; k++) begin
            tick(64'd0, 64'd1 << k, "rst");
        end
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_frames", frames_o, 64'd0);
        check("mid_rst_sot", {56'd0, sot_o}, 64'h02);
        check("mid_rst_busy", {63'd0, busy_o}, 64'd0);
        check("mid_rst_cnt", {48'd0, frame_cnt_o}, 64'd0);
        exp_q.delete(); due_q.delete(); tag_q.delete();
        sot_exp_q.delete(); sot_due_q.delete();
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check("post_rst_sot", {56'd0, sot_o}, 64'h80);
        check("post_rst_busy", {63'd0, busy_o}, 64'd0);
        check("post_rst_cnt", {48'd0, frame_cnt_o}, 64'd0);

        // Drain and report
        repeat (3) tick(64'd0, 64'd0, "tail");
        repeat (3) @(negedge clock);
        #1;
        check("sb_drain", 64'(due_q.size() + sot_due_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
